// File: rtl/hyperbus_arbiter_pkg.sv
// Shared types and sizing helpers for the two-port HyperBus arbiter.
package hyperbus_pkg;

  localparam int NPORTS = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_XFER  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  // Beat counter needs one extra bit so it can hold len itself.
  function automatic int beat_cnt_w(input int len_width);
    return len_width + 1;
  endfunction

  function automatic int tmo_cnt_w(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/hyperbus_arbiter_if.sv
// Client-port and controller-side signal bundle for hyperbus_arbiter.
interface hyperbus_arbiter_if #(
  parameter int WIDTH       = 8,
  parameter int ADDR_LENGTH = 32,
  parameter int LEN_WIDTH   = 8
) ();

  logic                   p0_req,    p1_req;
  logic                   p0_we,     p1_we;
  logic [ADDR_LENGTH-1:0] p0_adr,    p1_adr;
  logic [LEN_WIDTH-1:0]   p0_len,    p1_len;
  logic [2*WIDTH-1:0]     p0_wdat,   p1_wdat;
  logic                   p0_wready, p1_wready;
  logic [2*WIDTH-1:0]     p0_rdat,   p1_rdat;
  logic                   p0_rvalid, p1_rvalid;
  logic                   p0_done,   p1_done;
  logic                   p0_err,    p1_err;

  logic [ADDR_LENGTH-1:0] hb_adr;
  logic [2*WIDTH-1:0]     hb_dat_w;
  logic                   hb_wrq, hb_rrq, hb_reg_space;
  logic [2*WIDTH-1:0]     hb_dat_r;
  logic                   hb_ready, hb_valid, hb_busy, hb_error;
  logic                   fault;

  // Arbiter side.
  modport slave (
    input  p0_req, p1_req, p0_we, p1_we, p0_adr, p1_adr, p0_len, p1_len,
    input  p0_wdat, p1_wdat,
    output p0_wready, p1_wready, p0_rdat, p1_rdat, p0_rvalid, p1_rvalid,
    output p0_done, p1_done, p0_err, p1_err,
    output hb_adr, hb_dat_w, hb_wrq, hb_rrq, hb_reg_space, fault,
    input  hb_dat_r, hb_ready, hb_valid, hb_busy, hb_error
  );

  // Clients plus controller, as seen from outside the arbiter.
  modport master (
    output p0_req, p1_req, p0_we, p1_we, p0_adr, p1_adr, p0_len, p1_len,
    output p0_wdat, p1_wdat,
    input  p0_wready, p1_wready, p0_rdat, p1_rdat, p0_rvalid, p1_rvalid,
    input  p0_done, p1_done, p0_err, p1_err,
    input  hb_adr, hb_dat_w, hb_wrq, hb_rrq, hb_reg_space, fault,
    output hb_dat_r, hb_ready, hb_valid, hb_busy, hb_error
  );

endinterface

// File: rtl/hyperbus_arbiter_rr2.sv
// Two-way round-robin picker: on contention the port not granted last wins.
module hyperbus_rr2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = i_req;
    if (&i_req) o_grant = i_last ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/hyperbus_arbiter.sv
// Two-port burst arbiter in front of a single HyperBus controller, with
// per-burst timeout and a sticky fault state on controller error.
module hyperbus_arbiter
  import hyperbus_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int ADDR_LENGTH = 32,
  parameter int LEN_WIDTH   = 8,
  parameter int TIMEOUT     = 1023
) (
  input logic               clk,
  input logic               rst,
  hyperbus_arbiter_if.slave bus
);

  localparam int BW = beat_cnt_w(LEN_WIDTH);
  localparam int TW = tmo_cnt_w(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t                 r_state;
  logic                   r_gnt, r_last, r_we, r_err_pend;
  logic                   r_wrq, r_rrq, r_fault;
  logic [ADDR_LENGTH-1:0] r_adr;
  logic [LEN_WIDTH-1:0]   r_len;
  logic [BW-1:0]          r_beats;
  logic [TW-1:0]          r_tmo;
  logic [NPORTS-1:0]      r_done, r_err;

  logic [NPORTS-1:0]      w_req, w_pick, w_wready, w_rvalid;
  logic                   w_we_p   [NPORTS];
  logic [ADDR_LENGTH-1:0] w_adr_p  [NPORTS];
  logic [LEN_WIDTH-1:0]   w_len_p  [NPORTS];
  logic [2*WIDTH-1:0]     w_wdat_p [NPORTS];
  logic                   w_any, w_more, w_fwd_w, w_fwd_r, w_beat, w_last;

  assign w_req       = {bus.p1_req, bus.p0_req};
  assign w_we_p[0]   = bus.p0_we;
  assign w_we_p[1]   = bus.p1_we;
  assign w_adr_p[0]  = bus.p0_adr;
  assign w_adr_p[1]  = bus.p1_adr;
  assign w_len_p[0]  = bus.p0_len;
  assign w_len_p[1]  = bus.p1_len;
  assign w_wdat_p[0] = bus.p0_wdat;
  assign w_wdat_p[1] = bus.p1_wdat;

  hyperbus_rr2 u_rr (
    .i_req   (w_req),
    .i_last  (r_last),
    .o_grant (w_pick)
  );

  assign w_any   = |w_pick;
  // Only beats up to the latched length are forwarded; extras are swallowed.
  assign w_more  = r_beats < {1'b0, r_len};
  assign w_fwd_w = (r_state == ST_XFER) &&  r_we && bus.hb_ready && w_more;
  assign w_fwd_r = (r_state == ST_XFER) && !r_we && bus.hb_valid && w_more;
  assign w_beat  = w_fwd_w || w_fwd_r;
  assign w_last  = w_beat && ((r_beats + BW'(1)) == {1'b0, r_len});

  for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
    assign w_wready[gi] = w_fwd_w && (r_gnt == 1'(gi));
    assign w_rvalid[gi] = w_fwd_r && (r_gnt == 1'(gi));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_gnt      <= 1'b0;
      r_last     <= 1'b1;
      r_we       <= 1'b0;
      r_err_pend <= 1'b0;
      r_wrq      <= 1'b0;
      r_rrq      <= 1'b0;
      r_fault    <= 1'b0;
      r_adr      <= '0;
      r_len      <= '0;
      r_beats    <= '0;
      r_tmo      <= '0;
      r_done     <= '0;
      r_err      <= '0;
    end else begin
      r_done <= '0;
      r_err  <= '0;
      if (bus.hb_error) begin
        r_state <= ST_FAULT;
        r_wrq   <= 1'b0;
        r_rrq   <= 1'b0;
        r_fault <= 1'b1;
        if (r_state == ST_XFER || r_state == ST_DRAIN) begin
          r_done[r_gnt] <= 1'b1;
          r_err[r_gnt]  <= 1'b1;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_any && !bus.hb_busy) begin
              r_gnt   <= w_pick[1];
              r_we    <= w_we_p[w_pick[1]];
              r_adr   <= w_adr_p[w_pick[1]];
              r_len   <= w_len_p[w_pick[1]];
              r_beats <= '0;
              r_tmo   <= '0;
              if (w_len_p[w_pick[1]] == '0) begin
                // Zero-length burst is rejected without touching the controller.
                r_err_pend         <= 1'b1;
                r_done[w_pick[1]]  <= 1'b1;
                r_err[w_pick[1]]   <= 1'b1;
                r_state            <= ST_DONE;
              end else begin
                r_err_pend <= 1'b0;
                r_wrq      <= w_we_p[w_pick[1]];
                r_rrq      <= !w_we_p[w_pick[1]];
                r_state    <= ST_XFER;
              end
            end
          end
          ST_XFER: begin
            r_tmo <= r_tmo + TW'(1);
            if (w_beat) r_beats <= r_beats + BW'(1);
            if (w_last) begin
              r_wrq   <= 1'b0;
              r_rrq   <= 1'b0;
              r_state <= ST_DRAIN;
            end else if (r_tmo == TMO_LAST) begin
              r_wrq      <= 1'b0;
              r_rrq      <= 1'b0;
              r_err_pend <= 1'b1;
              r_state    <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            if (!bus.hb_busy) begin
              r_done[r_gnt] <= 1'b1;
              r_err[r_gnt]  <= r_err_pend;
              r_state       <= ST_DONE;
            end
          end
          ST_DONE: begin
            r_last  <= r_gnt;
            r_state <= ST_IDLE;
          end
          ST_FAULT: r_state <= ST_FAULT;
          default:  r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.hb_adr       = r_adr;
  assign bus.hb_dat_w     = w_wdat_p[r_gnt];
  assign bus.hb_wrq       = r_wrq;
  assign bus.hb_rrq       = r_rrq;
  assign bus.hb_reg_space = 1'b0;
  assign bus.fault        = r_fault;

  assign bus.p0_wready = w_wready[0];
  assign bus.p1_wready = w_wready[1];
  assign bus.p0_rvalid = w_rvalid[0];
  assign bus.p1_rvalid = w_rvalid[1];
  assign bus.p0_rdat   = bus.hb_dat_r;
  assign bus.p1_rdat   = bus.hb_dat_r;
  assign bus.p0_done   = r_done[0];
  assign bus.p1_done   = r_done[1];
  assign bus.p0_err    = r_err[0];
  assign bus.p1_err    = r_err[1];

endmodule
